// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet parser: default start marker,
// FSM state encoding and the packet checksum helper.
// Build option: PKT_CHECKSUM_EN adds the S_CHK state (4-byte packets).
package uart_pkt_pkg;

    localparam logic [7:0] START_BYTE_DEF = 8'hAA;

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_CHAN   = 3'd1,
        S_DATA   = 3'd2,
`ifdef PKT_CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_COMMIT = 3'd3
    } state_t;

    // Packet checksum: channel id XOR data byte.
    function automatic logic [7:0] pkt_chk(input logic [7:0] ch, input logic [7:0] data);
        return ch ^ data;
    endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-byte timeout: loadable down-counter. 'clear' reloads the full
// interval, 'enable' counts one idle clock, 'expired' is a single-cycle
// pulse on the enabled clock that exhausts the interval (never while clear).
module uart_pkt_timeout #(
    parameter int unsigned LOAD = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CW     = $clog2(LOAD + 1);
    localparam logic [CW-1:0]   LOAD_V = CW'(LOAD);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A byte arriving on the same edge as expiry wins, hence the !clear term.
    assign expired = enable && !clear && (cnt_q == CW'(1));

    // Reload on clear or expiry, otherwise count down while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = LOAD_V;
        end else if (enable) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LOAD_V;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_packet_parser.sv
// UART packet parser: frames START, CH_ID, DATA [, CHK] from the rx byte
// handshake, writes DATA into a per-channel register bank with a one-cycle
// update strobe, and keeps error / good-packet counters.
// Accepted bytes are registered first and interpreted by the FSM on the
// following clock, giving a 2-clock accept-to-update latency.
// Build option: define PKT_CHECKSUM_EN for 4-byte packets with checksum.
module uart_packet_parser
    import uart_pkt_pkg::*;
#(
    parameter int          NUM_CH         = 2,
    parameter logic [7:0]  START_BYTE     = START_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_valid,
    output logic                  rx_data_ready,
    output logic [NUM_CH*8-1:0]   ch_data,
    output logic [NUM_CH-1:0]     ch_update,
    output logic                  pkt_err,
    output logic [7:0]            err_cnt,
    output logic [15:0]           pkt_cnt
);

    localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

    state_t      state_q, state_d;
    logic        rdy_q;
    logic [7:0]  byte_q;
    logic        byte_vld_q;
    logic [7:0]  ch_q;
    logic [7:0]  data_q;
    logic        pkt_err_q;
    logic [7:0]  err_cnt_q;
    logic [15:0] pkt_cnt_q;

    logic        accept;
    logic        ch_ok;
    logic        tmo_enable;
    logic        tmo_clear;
    logic        tmo_expired;
    logic        latch_ch;
    logic        latch_data;
    logic        commit;
    logic        error;

    assign accept = rx_data_valid && rdy_q;
    assign ch_ok  = (byte_q != 8'd0) && (byte_q <= NUM_CH_B);

`ifdef PKT_CHECKSUM_EN
    logic chk_ok;
    assign chk_ok = (byte_q == pkt_chk(ch_q, data_q));
`endif

    // Timer only runs while inside a packet; every accepted byte restarts it.
    assign tmo_enable = (state_q == S_CHAN) || (state_q == S_DATA)
`ifdef PKT_CHECKSUM_EN
                        || (state_q == S_CHK)
`endif
                        ;
    assign tmo_clear  = accept || !tmo_enable;

    uart_pkt_timeout #(
        .LOAD (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: advance on each registered byte, abort on bad field or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HUNT: begin
                if (byte_vld_q && (byte_q == START_BYTE)) state_d = S_CHAN;
            end
            S_CHAN: begin
                if (byte_vld_q)       state_d = ch_ok ? S_DATA : S_HUNT;
                else if (tmo_expired) state_d = S_HUNT;
            end
            S_DATA: begin
                if (byte_vld_q) begin
`ifdef PKT_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_COMMIT;
`endif
                end else if (tmo_expired) begin
                    state_d = S_HUNT;
                end
            end
`ifdef PKT_CHECKSUM_EN
            S_CHK: begin
                if (byte_vld_q)       state_d = chk_ok ? S_COMMIT : S_HUNT;
                else if (tmo_expired) state_d = S_HUNT;
            end
`endif
            S_COMMIT: state_d = S_HUNT;
            default:  state_d = S_HUNT;
        endcase
    end

    // FSM outputs: field latches, commit strobe and error detection.
    always_comb begin
        latch_ch   = 1'b0;
        latch_data = 1'b0;
        commit     = 1'b0;
        error      = tmo_expired;
        case (state_q)
            S_CHAN: begin
                latch_ch = byte_vld_q;
                if (byte_vld_q && !ch_ok) error = 1'b1;
            end
            S_DATA: latch_data = byte_vld_q;
`ifdef PKT_CHECKSUM_EN
            S_CHK: begin
                if (byte_vld_q && !chk_ok) error = 1'b1;
            end
`endif
            S_COMMIT: commit = 1'b1;
            default: ;
        endcase
    end

    // Byte handshake, packet fields, error pulse and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b1;
            byte_q     <= 8'd0;
            byte_vld_q <= 1'b0;
            ch_q       <= 8'd0;
            data_q     <= 8'd0;
            pkt_err_q  <= 1'b0;
            err_cnt_q  <= 8'd0;
            pkt_cnt_q  <= 16'd0;
        end else begin
            rdy_q      <= !accept;
            byte_vld_q <= accept;
            if (accept)     byte_q <= rx_data;
            if (latch_ch)   ch_q   <= byte_q;
            if (latch_data) data_q <= byte_q;
            pkt_err_q  <= error;
            if (error && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
            if (commit) pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    // Per-channel register bank; the strobe rises with the data update.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [7:0] CH_ID = 8'(gi + 1);
            logic [7:0] data_reg_q;
            logic       upd_q;

            // Channel register and its update pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg_q <= 8'd0;
                    upd_q      <= 1'b0;
                end else begin
                    upd_q <= commit && (ch_q == CH_ID);
                    if (commit && (ch_q == CH_ID)) data_reg_q <= data_q;
                end
            end

            assign ch_data[gi*8 +: 8] = data_reg_q;
            assign ch_update[gi]      = upd_q;
        end
    endgenerate

    assign rx_data_ready = rdy_q;
    assign pkt_err       = pkt_err_q;
    assign err_cnt       = err_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Scoreboard bench for uart_packet_parser: stimulus pushes the expected
// update/error event before sending a packet; a negedge monitor pops and
// compares whenever ch_update or pkt_err is seen.
// Works with or without PKT_CHECKSUM_EN defined.
module tb_uart_packet_parser;

    localparam int          NUM_CH = 2;
    localparam int unsigned TMO    = 20;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [7:0]            rx_data;
    logic                  rx_data_valid;
    logic                  rx_data_ready;
    logic [NUM_CH*8-1:0]   ch_data;
    logic [NUM_CH-1:0]     ch_update;
    logic                  pkt_err;
    logic [7:0]            err_cnt;
    logic [15:0]           pkt_cnt;

    always #5 clk = ~clk;

    uart_packet_parser #(
        .NUM_CH         (NUM_CH),
        .START_BYTE     (8'hAA),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .ch_data       (ch_data),
        .ch_update     (ch_update),
        .pkt_err       (pkt_err),
        .err_cnt       (err_cnt),
        .pkt_cnt       (pkt_cnt)
    );

    typedef struct {
        bit                is_upd;
        logic [NUM_CH-1:0] upd;
        logic [15:0]       data;
        logic [7:0]        err;
        logic [15:0]       pkt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_ch   = 16'h0;
    logic [7:0]  exp_err  = 8'h0;
    logic [15:0] exp_pkt  = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_upd(input int ch, input logic [7:0] d);
        exp_t e;
        exp_ch[(ch-1)*8 +: 8] = d;
        exp_pkt  = exp_pkt + 16'd1;
        e.is_upd = 1'b1;
        e.upd    = NUM_CH'(1 << (ch - 1));
        e.data   = exp_ch;
        e.err    = exp_err;
        e.pkt    = exp_pkt;
        sb_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        e.is_upd = 1'b0;
        e.upd    = '0;
        e.data   = exp_ch;
        e.err    = exp_err;
        e.pkt    = exp_pkt;
        sb_q.push_back(e);
    endtask

    // Monitor: one scoreboard entry per update or error pulse.
    always @(negedge clk) begin
        if (rst_n && ((ch_update != '0) || pkt_err)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_event", {30'd0, pkt_err, |ch_update}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ev_pkt_err", {31'd0, pkt_err}, {31'd0, !e.is_upd});
                check("ev_ch_update", {30'd0, ch_update}, {30'd0, e.upd});
                check("ev_ch_data", {16'd0, ch_data}, {16'd0, e.data});
                check("ev_err_cnt", {24'd0, err_cnt}, {24'd0, e.err});
                check("ev_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, e.pkt});
                $display("event %s upd=%b data=%h err_cnt=%0d pkt_cnt=%0d",
                         e.is_upd ? "update" : "error ", ch_update, ch_data, err_cnt, pkt_cnt);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!rx_data_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, rx_data_ready}, 32'd1);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
        check("ready_low_after_accept", {31'd0, rx_data_ready}, 32'd0);
    endtask

    task automatic send_pkt(input logic [7:0] ch, input logic [7:0] d);
        send_byte(8'hAA);
        send_byte(ch);
        send_byte(d);
`ifdef PKT_CHECKSUM_EN
        send_byte(ch ^ d);
`endif
    endtask

    initial begin
        int k;
        rst_n         = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, rx_data_ready}, 32'd1);
        check("rst_ch_data", {16'd0, ch_data}, 32'd0);
        check("rst_ch_update", {30'd0, ch_update}, 32'd0);
        check("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good packet on channel 1.
        push_upd(1, 8'h5C);
        send_pkt(8'h01, 8'h5C);
        repeat (4) @(negedge clk);

        // Good packet on channel 2; with checksum, also a bad checksum.
        push_upd(2, 8'h33);
        send_pkt(8'h02, 8'h33);
`ifdef PKT_CHECKSUM_EN
        push_err();
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h33); send_byte(8'h00);
`endif
        repeat (4) @(negedge clk);

        // Out-of-range channel; trailing byte is discarded while hunting.
        push_err();
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        repeat (4) @(negedge clk);

        // Noise, then CH_ID=AA error, stray 01, then a full packet.
        push_err();
        push_upd(1, 8'h77);
        send_byte(8'h12); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h01);
        send_pkt(8'h01, 8'h77);
        repeat (4) @(negedge clk);

        // Start marker as payload.
        push_upd(2, 8'hAA);
        send_pkt(8'h02, 8'hAA);
        repeat (4) @(negedge clk);

        // Timeout after CH_ID, then recovery.
        push_err();
        send_byte(8'hAA); send_byte(8'h01);
        k = 0;
        for (int i = 1; i <= int'(TMO) + 10; i++) begin
            @(posedge clk);
            #1;
            if (pkt_err) begin
                k = i;
                break;
            end
        end
        check("timeout_cycles", k, TMO);
        push_upd(1, 8'h7E);
        send_pkt(8'h01, 8'h7E);
        repeat (4) @(negedge clk);

        // Error counter saturation.
        for (int i = 0; i < 256; i++) begin
            push_err();
            send_byte(8'hAA); send_byte(8'h05);
        end
        repeat (4) @(negedge clk);
        check("err_cnt_saturated", {24'd0, err_cnt}, 32'hFF);
        check("sb_drained_before_reset", sb_q.size(), 0);

        // Reset in the middle of a packet.
        send_byte(8'hAA); send_byte(8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, rx_data_ready}, 32'd1);
        check("midrst_ch_data", {16'd0, ch_data}, 32'd0);
        check("midrst_ch_update", {30'd0, ch_update}, 32'd0);
        check("midrst_pkt_err", {31'd0, pkt_err}, 32'd0);
        check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("midrst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        exp_ch  = 16'h0;
        exp_err = 8'h0;
        exp_pkt = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_upd(1, 8'h44);
        send_pkt(8'h01, 8'h44);
        repeat (6) @(negedge clk);
        check("sb_drained_at_end", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
